// File: rtl/mem_seq_pkg.sv
// Shared types for the memory command sequencer.
// Command and response bundles carried through the sequencer FIFOs.
package mem_seq_pkg;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    localparam int MEM_ADDR_W = 3;
    localparam int MEM_DATA_W = 8;

    typedef struct packed {
        logic                  op;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] data;
    } cmd_t;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] data;
    } rsp_t;

endpackage

// File: rtl/mem_cmd_sequencer_fifo.sv
// Synchronous FIFO with wrap-bit pointers and occupancy count.
// Registered storage; no fall-through from push to pop.
module seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (wptr_q[AW] != rptr_q[AW]) &&
                  (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        empty   = (wptr_q == rptr_q);
        do_push = push && !full;
        do_pop  = pop && !empty;
        wptr_d  = wptr_q + (AW+1)'(do_push);
        rptr_d  = rptr_q + (AW+1)'(do_pop);
        count   = wptr_q - rptr_q;
        rdata   = mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

    // Upstream flow control must make these impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (!resetn)
        !(pop && empty));

endmodule

// File: rtl/mem_cmd_sequencer.sv
// In-order command issue to an 8-entry register memory with
// credit-limited reads and a buffered response stream.
module mem_cmd_sequencer
    import mem_seq_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int ADDR_W    = MEM_ADDR_W,
    parameter int DATA_W    = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_error,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              err_sticky,
    output logic              busy
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam logic [CAW:0]   CMD_LIM = (CAW+1)'(CMD_DEPTH);
    localparam logic [RAW+1:0] RSP_LIM = (RAW+2)'(RSP_DEPTH);

    cmd_t            cmd_in;
    cmd_t            cmd_head;
    rsp_t            rsp_in;
    rsp_t            rsp_head;
    logic [CAW:0]    cmd_count;
    logic [RAW:0]    rsp_count;
    logic            cmd_empty;
    logic            cmd_full;
    logic            rsp_empty;
    logic            cmd_push;
    logic            cmd_pop;
    logic            rsp_pop;
    logic [RAW+1:0]  credit_used;
    logic            credit_ok;
    logic            issue_wr;
    logic            issue_rd;

    logic              mem_wr_q, mem_wr_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              err_q, err_d;

    always_comb begin
        cmd_in.op   = cmd_op;
        cmd_in.addr = cmd_addr;
        cmd_in.data = cmd_data;
        cmd_empty   = (cmd_count == '0);
        cmd_full    = (cmd_count == CMD_LIM);
        rsp_empty   = (rsp_count == '0);
        cmd_ready   = !cmd_full;
        cmd_push    = cmd_valid && !cmd_full;
        rsp_valid   = !rsp_empty;
        rsp_pop     = rsp_valid && rsp_ready;
        rsp_in.addr = pend_addr_q;
        rsp_in.data = mem_dout;
    end

    seq_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (cmd_push),
        .wdata  (cmd_in),
        .pop    (cmd_pop),
        .rdata  (cmd_head),
        .count  (cmd_count)
    );

    seq_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (pend_q),
        .wdata  (rsp_in),
        .pop    (rsp_pop),
        .rdata  (rsp_head),
        .count  (rsp_count)
    );

    // Buffered plus in-flight reads may never exceed response slots.
    always_comb begin
        credit_used = {1'b0, rsp_count}
                    + {{(RAW+1){1'b0}}, mem_rd_q}
                    + {{(RAW+1){1'b0}}, pend_q};
        credit_ok   = credit_used < RSP_LIM;
        issue_wr    = !cmd_empty && (cmd_head.op == OP_WRITE);
        issue_rd    = !cmd_empty && (cmd_head.op == OP_READ) && credit_ok;
        cmd_pop     = issue_wr || issue_rd;
    end

    always_comb begin
        mem_wr_d    = issue_wr;
        mem_rd_d    = issue_rd;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        if (issue_wr) begin
            mem_addr_d = cmd_head.addr;
            mem_din_d  = cmd_head.data;
        end else if (issue_rd) begin
            mem_addr_d = cmd_head.addr;
            mem_din_d  = '0;
        end
        pend_d      = mem_rd_q;
        pend_addr_d = mem_rd_q ? mem_addr_q : pend_addr_q;
        err_d       = err_q | mem_error;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_wr_q    <= mem_wr_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        mem_wr     = mem_wr_q;
        mem_rd     = mem_rd_q;
        mem_addr   = mem_addr_q;
        mem_din    = mem_din_q;
        rsp_data   = rsp_valid ? rsp_head.data : '0;
        rsp_addr   = rsp_valid ? rsp_head.addr : '0;
        err_sticky = err_q;
        busy       = !cmd_empty || !rsp_empty || mem_rd_q || pend_q;
    end

endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// Directed self-checking bench for mem_cmd_sequencer with a
// behavioural 8-entry valid-tracked register memory.
module tb_mem_cmd_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_op = 1'b0;
    logic [2:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       mem_wr, mem_rd;
    logic [2:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;
    logic       mem_error = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [2:0] rsp_addr;
    logic       err_sticky;
    logic       busy;

    int total = 0;
    int bad = 0;
    int rd_pulses = 0;
    int excl_bad = 0;
    logic [10:0] rq[$];

    logic [7:0] mdat [8];
    logic [7:0] mvld;

    always #5 clk = ~clk;

    mem_cmd_sequencer dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .mem_wr     (mem_wr),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_error  (mem_error),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_addr   (rsp_addr),
        .err_sticky (err_sticky),
        .busy       (busy)
    );

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mvld     <= '0;
            mem_dout <= '0;
        end else begin
            if (mem_wr) begin
                mdat[mem_addr] <= mem_din;
                mvld[mem_addr] <= 1'b1;
            end
            if (mem_rd) begin
                mem_dout <= mvld[mem_addr] ? mdat[mem_addr] : 8'h00;
            end
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            if (rsp_valid && rsp_ready) rq.push_back({rsp_addr, rsp_data});
            if (mem_rd) rd_pulses++;
            if (mem_wr && mem_rd) excl_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic op, input logic [2:0] a,
                        input logic [7:0] d, output int stalls);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        stalls    = 0;
        while (!cmd_ready && stalls < 50) begin
            tick(1);
            stalls++;
        end
        if (!cmd_ready) chk("send_timeout", 0, 1);
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_q(input int n);
        int c = 0;
        while (rq.size() < n && c < 200) begin
            tick(1);
            c++;
        end
        chk("rsp_count", rq.size(), n);
    endtask

    initial begin
        int st;
        int st_sum;

        // reset and idle
        tick(2);
        @(negedge clk);
        resetn = 1'b1;
        tick(1);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_mem", {mem_wr, mem_rd, mem_addr, mem_din}, 0);
        chk("rst_rsp", {rsp_valid, rsp_data, rsp_addr}, 0);
        chk("rst_err", err_sticky, 0);
        chk("rst_busy", busy, 0);

        // write 3=A5 then read 3
        send(1'b0, 3'd3, 8'hA5, st);
        chk("wr_not_yet", mem_wr, 0);
        send(1'b1, 3'd3, 8'h00, st);
        chk("wr_cycle", {mem_wr, mem_rd, mem_addr, mem_din},
            {1'b1, 1'b0, 3'd3, 8'hA5});
        tick(1);
        chk("rd_cycle", {mem_wr, mem_rd, mem_addr, mem_din},
            {1'b0, 1'b1, 3'd3, 8'h00});
        tick(1);
        chk("raw_lat_early", rsp_valid, 0);
        tick(1);
        chk("raw_rsp", {rsp_valid, rsp_addr, rsp_data},
            {1'b1, 3'd3, 8'hA5});
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        tick(1);
        chk("raw_drained", {rsp_valid, busy}, 0);
        rq.delete();

        // never-written address
        send(1'b1, 3'd6, 8'h00, st);
        tick(4);
        chk("unwr_rsp", {rsp_valid, rsp_addr, rsp_data},
            {1'b1, 3'd6, 8'h00});
        chk("unwr_err", err_sticky, 0);
        rsp_ready = 1'b1;
        tick(2);
        rq.delete();

        // back-to-back 8 writes then 8 reads
        st_sum = 0;
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 3'(i), 8'(i * 8'h11), st);
            st_sum += st;
        end
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 3'(i), 8'h00, st);
            st_sum += st;
        end
        chk("b2b_stalls", st_sum, 0);
        wait_q(8);
        for (int i = 0; i < 8; i++) begin
            if (i < rq.size())
                chk($sformatf("b2b_rsp%0d", i), rq[i],
                    {3'(i), 8'(i * 8'h11)});
        end
        tick(3);
        chk("b2b_busy", busy, 0);
        rq.delete();

        // backpressure: credit limit and full command FIFO
        rsp_ready = 1'b0;
        rd_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 3'(7 - i), 8'h00, st);
        end
        tick(6);
        chk("bp_ready", cmd_ready, 0);
        chk("bp_rd_idle", mem_rd, 0);
        chk("bp_rd_cnt", rd_pulses, 4);
        chk("bp_head", {rsp_valid, rsp_addr, rsp_data},
            {1'b1, 3'd7, 8'h77});
        rsp_ready = 1'b1;
        wait_q(8);
        tick(5);
        chk("bp_no_dup", rq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < rq.size())
                chk($sformatf("bp_rsp%0d", i), rq[i],
                    {3'(7 - i), 8'((7 - i) * 8'h11)});
        end
        chk("bp_busy", busy, 0);
        chk("wr_rd_excl", excl_bad, 0);
        rq.delete();

        // sticky error
        mem_error = 1'b1;
        tick(1);
        mem_error = 1'b0;
        chk("err_set", err_sticky, 1);
        tick(3);
        chk("err_hold", err_sticky, 1);

        // reset mid-burst
        rsp_ready = 1'b0;
        send(1'b1, 3'd1, 8'h00, st);
        send(1'b1, 3'd2, 8'h00, st);
        send(1'b1, 3'd5, 8'h00, st);
        tick(3);
        chk("mid_pre", rsp_valid, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_async", {rsp_valid, busy, err_sticky, mem_rd}, 0);
        chk("mid_ready", cmd_ready, 1);
        @(negedge clk);
        resetn = 1'b1;
        tick(1);
        chk("mid_after", {rsp_valid, busy, cmd_ready}, 3'b001);
        rq.delete();
        rsp_ready = 1'b1;
        send(1'b1, 3'd5, 8'h00, st);
        wait_q(1);
        if (rq.size() > 0) chk("mid_lost", rq[0], {3'd5, 8'h00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_cmd_sequencer.md
Name: mem_cmd_sequencer

Overview:
Upstream command front-end for the team's 8-entry valid-tracked register memory. Accepts read/write commands on a valid/ready stream and buffers them. Issues them in order to the memory's wr/rd/addr/din port, never asserting wr and rd together. Captures read data returned one cycle later and presents it on a valid/ready response stream with backpressure-safe credit control.

Parameters:
CMD_DEPTH, 4, command FIFO entries; power of 2, at least 2
RSP_DEPTH, 4, response FIFO entries; power of 2, at least 2; also the read-credit limit
ADDR_W, 3, memory address width (8 entries)
DATA_W, 8, data width

Ports:
clk  in  1  single clock, rising edge
resetn  in  1  asynchronous active-low reset (decided: async assert, one clock domain)
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  1  0 = write, 1 = read
cmd_addr  in  ADDR_W  target address
cmd_data  in  DATA_W  write data; ignored for reads
mem_wr  out  1  memory write-enable, registered
mem_rd  out  1  memory read-enable, registered
mem_addr  out  ADDR_W  memory address, registered
mem_din  out  DATA_W  memory write data, registered
mem_dout  in  DATA_W  memory registered read data
mem_error  in  1  memory invalid-op flag
rsp_valid  out  1  read response available
rsp_ready  in  1  consumer takes response when rsp_valid && rsp_ready
rsp_data  out  DATA_W  read data; 0 for never-written address
rsp_addr  out  ADDR_W  address of the read
err_sticky  out  1  set if mem_error is ever seen high; cleared only by reset
busy  out  1  high when any FIFO is non-empty or any read is in flight

Behaviour:
- Reset (async, resetn low): both FIFOs empty; pointers 0; in-flight reads discarded. Reset values: mem_wr=0, mem_rd=0, mem_addr=0, mem_din=0, rsp_valid=0, rsp_data=0, rsp_addr=0, err_sticky=0, busy=0. cmd_ready=1 in the first cycle after release. Memory shares resetn, so reset mid-operation loses all state coherently.
- Command FIFO: cmd_ready = !cmd_full. No fall-through: an entry accepted at edge k is issuable at edge k+1 at the earliest. Pointers carry one extra wrap bit. Full = MSBs differ and LSBs equal. Push and pop in the same cycle are allowed at any non-full, non-empty occupancy.
- Issue (at most one per cycle, strict program order):
  - Head is a write: at the next edge, pop; mem_wr=1, mem_rd=0, addr/din loaded from head.
  - Head is a read: issued only if rsp_count + inflight < RSP_DEPTH. Then pop; mem_rd=1, mem_wr=0, mem_addr loaded; mem_din=0.
  - Otherwise (empty or no credit): mem_wr=mem_rd=0; addr/din hold.
- Read pipeline:
  - rd issued at edge t (mem_rd high during cycle t).
  - The memory updates mem_dout at edge t+1.
  - pend flag and pend_addr register at edge t+1.
  - At edge t+2, mem_dout and pend_addr are pushed into the response FIFO.
  - inflight = mem_rd + pend (0..2).
- Latency: read accepted at edge k with idle pipeline gives rsp_valid high from edge k+3. Write accepted at edge k gives mem_wr high during cycle k+1.
- Throughput: one command per cycle sustained while rsp_ready=1.
- Response FIFO: rsp_valid = !rsp_empty; outputs are driven from the head. Credit guarantees a push never meets a full FIFO. An overflow attempt is a design error; flag it with an assertion.
- Ordering: read-after-write to the same address returns the new data, because the memory sees the write first. A read to a never-written address returns 0.
- err_sticky <= err_sticky | mem_error each cycle.
- busy = !cmd_empty | !rsp_empty | mem_rd | pend.

Decomposition:
- Package mem_seq_pkg: OP_WRITE=1'b0, OP_READ=1'b1; ADDR_W/DATA_W defaults; packed struct cmd_t {op, addr, data}; packed struct rsp_t {addr, data}.
- Sub-module seq_fifo (parameterised WIDTH, DEPTH; push/pop, full/empty, count). Instantiated twice: command FIFO (width 1+ADDR_W+DATA_W) and response FIFO (width ADDR_W+DATA_W).
- Top: issue logic, read pipeline, credit counter, sticky error.

Test Plan:
- Reset release, idle: cmd_ready=1, all outputs 0, busy=0. Assert resetn mid-burst: rsp_valid drops to 0 asynchronously and the FIFOs empty.
- Write addr 3 = 0xA5 at edge k, then read addr 3 -> mem_wr during cycle k+1; rsp_data=0xA5, rsp_addr=3, rsp_valid from the read's accept edge +3.
- Read addr 6, never written -> rsp_data=0x00, rsp_addr=6; err_sticky stays 0.
- Back-to-back 8 writes (data = addr*0x11) then 8 reads with rsp_ready=1 -> one command per cycle; responses 0x00,0x11,…,0x77 in order; mem_wr&&mem_rd never true.
- Hold rsp_ready=0, push 8 reads -> exactly RSP_DEPTH=4 reads issued, then mem_rd stays 0. cmd_ready drops once CMD_DEPTH=4 entries are queued. Release rsp_ready: all 8 responses arrive with no loss or duplication.
- Force mem_error=1 for one cycle -> err_sticky=1 and holds until resetn is asserted.
